// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM sequencing the multicycle RV32I datapath.
module multicycle_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
  } state_t;
  state_t state, next;
  logic taken, pc_upd, ir_upd;
  always_ff @(posedge clk) state <= reset ? FETCH : next;
  always_comb taken = funct3[2] ? ((funct3[1] ? ltu : lt) ^ funct3[0])
                                : (!funct3[1] && (zero ^ funct3[0]));
  always_comb begin
    next       = FETCH;
    pc_upd     = 1'b0;
    ir_upd     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_upd     = mem_ready;
        ir_upd     = mem_ready;
        next       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          7'b0000011, 7'b0100011: next = MEMADR;
          7'b0110011: next = EXECR;
          7'b0010011: next = EXECI;
          7'b1100011: next = BRANCH;
          7'b1101111: next = JAL;
          7'b1100111: next = JALR;
          7'b0110111: next = LUI;
          7'b0010111: next = AUIPC;
          default:    next = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        next      = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        next    = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        next      = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        next      = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        next      = ALUWB;
      end
      ALUWB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_upd    = taken;
      end
      // PC takes the target already in ALUOut while the ALU forms the link value.
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_upd    = 1'b1;
        next      = ALUWB;
      end
      JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        next      = JAL;
      end
      LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
      end
      AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        next      = ALUWB;
      end
      TRAP: begin
        illegal = 1'b1;
        next    = TRAP;
      end
      default: ;
    endcase
  end
  assign pc_write   = pc_upd && !reset;
  assign ir_write   = ir_upd && !reset;
  assign instr_done = !reset && next == FETCH && state != FETCH && state != TRAP;
  assign state_o    = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction streams checked against a per-instruction step model.
module tb_multicycle_controller;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_JALR = 6,
                 K_LUI = 7, K_AUIPC = 8, K_ILL = 9;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b1;
  logic pc_write1, ir_write1, adr_src1, mem_write1, reg_write1, instr_done1, illegal1;
  logic pc_write0, ir_write0, adr_src0, mem_write0, reg_write0, instr_done0, illegal0;
  logic [1:0] a1, b1, op1, rs1, a0, b0, op0, rs0;
  logic [3:0] st1, st0;
  logic [14:0] w1, w0;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .pc_write(pc_write1), .ir_write(ir_write1), .adr_src(adr_src1),
    .mem_write(mem_write1), .reg_write(reg_write1), .alu_src_a(a1), .alu_src_b(b1), .alu_op(op1),
    .result_src(rs1), .instr_done(instr_done1), .illegal(illegal1), .state_o(st1));

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .pc_write(pc_write0), .ir_write(ir_write0), .adr_src(adr_src0),
    .mem_write(mem_write0), .reg_write(reg_write0), .alu_src_a(a0), .alu_src_b(b0), .alu_op(op0),
    .result_src(rs0), .instr_done(instr_done0), .illegal(illegal0), .state_o(st0));

  assign w1 = {pc_write1, ir_write1, adr_src1, mem_write1, reg_write1, a1, b1, op1, rs1, instr_done1, illegal1};
  assign w0 = {pc_write0, ir_write0, adr_src0, mem_write0, reg_write0, a0, b0, op0, rs0, instr_done0, illegal0};

  // Expected control word for a state, straight from the state/output table.
  function automatic logic [14:0] exp_word(input int s, input logic mr, input logic tk, input logic done);
    logic pc, ir, adr, mw, rw, il;
    logic [1:0] a, b, op, rs;
    pc = 0; ir = 0; adr = 0; mw = 0; rw = 0; il = 0; a = 0; b = 0; op = 0; rs = 0;
    case (s)
      0:  begin b = 2; rs = 2; pc = mr; ir = mr; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2; op = 2; end
      7:  begin a = 2; b = 1; op = 2; end
      8:  rw = 1;
      9:  begin a = 2; op = 1; pc = tk; end
      10: begin a = 1; b = 2; pc = 1; end
      11: begin a = 2; b = 1; end
      12: begin rs = 3; rw = 1; end
      13: begin a = 1; b = 1; end
      14: il = 1;
      default: ;
    endcase
    return {pc, ir, adr, mw, rw, a, b, op, rs, done, il};
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return lu;
      3'd7: return !lu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] op_of(input int kind);
    logic [6:0] bad [4];
    bad = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};
    case (kind)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_LUI:   return 7'b0110111;
      K_AUIPC: return 7'b0010111;
      default: return bad[$urandom_range(0, 3)];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic step(input int s1, input int s0, input logic mr, input logic d1, input logic d0, input logic tk);
    @(negedge clk);
    mem_ready = mr;
    #1;
    chk("state", 15'(st1), 15'(s1));
    chk("ctl", w1, exp_word(s1, mr, tk, d1));
    chk("state_nop", 15'(st0), 15'(s0));
    chk("ctl_nop", w0, exp_word(s0, mr, tk, d0));
  endtask

  // Builds the expected state sequence of one instruction, then walks it cycle by cycle.
  task automatic run_instr(input int kind, input int fw, input int mw, input logic [2:0] f3,
                           input logic z, input logic l, input logic lu);
    int p[$];
    int nx, s0, nx0;
    logic tk, mr, d1, d0;
    opcode = op_of(kind);
    funct3 = f3; zero = z; lt = l; ltu = lu;
    tk = branch_taken(f3, z, l, lu);
    for (int j = 0; j <= fw; j++) p.push_back(0);
    p.push_back(1);
    case (kind)
      K_LW:    begin p.push_back(2); for (int j = 0; j <= mw; j++) p.push_back(3); p.push_back(4); end
      K_SW:    begin p.push_back(2); for (int j = 0; j <= mw; j++) p.push_back(5); end
      K_R:     begin p.push_back(6); p.push_back(8); end
      K_I:     begin p.push_back(7); p.push_back(8); end
      K_BR:    p.push_back(9);
      K_JAL:   begin p.push_back(10); p.push_back(8); end
      K_JALR:  begin p.push_back(11); p.push_back(10); p.push_back(8); end
      K_LUI:   p.push_back(12);
      K_AUIPC: begin p.push_back(13); p.push_back(8); end
      default: for (int j = 0; j < 10; j++) p.push_back(14);
    endcase
    for (int i = 0; i < p.size(); i++) begin
      nx  = (i + 1 < p.size()) ? p[i+1] : 0;
      s0  = (p[i] == 14) ? 0 : p[i];
      nx0 = (nx == 14) ? 0 : nx;
      if (p[i] == 0 || p[i] == 3 || p[i] == 5) mr = (nx != p[i]);
      else if (p[i] == 14) mr = 1'b0;
      else mr = 1'($urandom % 2);
      d1 = p[i] != 0 && p[i] != 14 && nx == 0;
      d0 = s0 != 0 && nx0 == 0;
      step(p[i], s0, mr, d1, d0, tk);
    end
    if (kind == K_ILL) begin
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("trap_reset", 15'(st1), 15'd0);
      chk("trap_reset_nop", 15'(st0), 15'd0);
      reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 15'(st1), 15'd0);
    chk("reset_ctl", w1, exp_word(0, 1'b0, 1'b0, 1'b0));
    chk("reset_ctl_nop", w0, exp_word(0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release_ctl", w1, exp_word(0, 1'b1, 1'b0, 1'b0));
    mem_ready = 1'b0;
    run_instr(K_R, 0, 0, 3'b000, 1'b0, 1'b0, 1'b0);
    run_instr(K_LW, 0, 3, 3'b010, 1'b0, 1'b0, 1'b0);
    run_instr(K_BR, 0, 0, 3'b001, 1'b0, 1'b0, 1'b0);
    run_instr(K_BR, 0, 0, 3'b001, 1'b1, 1'b0, 1'b0);
    run_instr(K_BR, 0, 0, 3'b110, 1'b0, 1'b0, 1'b1);
    run_instr(K_BR, 0, 0, 3'b110, 1'b0, 1'b1, 1'b0);
    run_instr(K_BR, 0, 0, 3'b010, 1'b1, 1'b1, 1'b1);
    run_instr(K_JALR, 0, 0, 3'b000, 1'b0, 1'b0, 1'b0);
    run_instr(K_ILL, 0, 0, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 150; n++)
      run_instr(int'($urandom_range(0, 9)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    opcode = 7'b0100011;
    step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("memwrite_reset_state", 15'(st1), 15'd0);
    chk("memwrite_reset_ctl", w1, exp_word(0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
